// File: rtl/avmm_burst_responder_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | avmm_burst_responder_if : Avalon-MM burst bus (initiator <-> BRAM responder) |
// | Revision 1.0                                                                |
// +----------------------------------------------------------------------------+
interface avmm_burst_responder_if #(
  parameter int DATA_W  = 128,
  parameter int ADDR_W  = 32,
  parameter int BURST_W = 5
);
  logic [ADDR_W-1:0]   address;
  logic [BURST_W-1:0]  burstcount;
  logic                read;
  logic                write;
  logic [DATA_W-1:0]   writedata;
  logic [DATA_W/8-1:0] byteenable;
  logic                waitrequest;
  logic [DATA_W-1:0]   readdata;
  logic                readdatavalid;

  modport master (
    output address, burstcount, read, write, writedata, byteenable,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, burstcount, read, write, writedata, byteenable,
    output waitrequest, readdata, readdatavalid
  );
endinterface
`default_nettype wire

// File: rtl/avmm_burst_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | avmm_burst_responder : Avalon-MM burst slave fronting a sync-read BRAM      |
// | Revision 1.0                                                                |
// +----------------------------------------------------------------------------+
module avmm_burst_responder #(
  parameter int DATA_W  = 128,
  parameter int ADDR_W  = 32,
  parameter int MEM_AW  = 12,
  parameter int BURST_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  avmm_burst_responder_if.slave bus,
  output logic [MEM_AW-1:0]     mem_addr,
  output logic                  mem_we,
  output logic [DATA_W/8-1:0]   mem_be,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic                  mem_re,
  input  logic [DATA_W-1:0]     mem_q,
  output logic                  proto_err
);
  localparam int BE_W     = DATA_W / 8;
  localparam int OFFSET_W = $clog2(BE_W);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_BURST = 2'd1,
    WR_BURST = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [MEM_AW-1:0]  addr_q, addr_d;
  logic [BURST_W-1:0] remaining_q, remaining_d;
  logic               ready_q, ready_d;
  logic               proto_err_q, proto_err_d;
  logic               rvalid_q, rvalid_d;
  logic               waitrequest;
  logic [MEM_AW-1:0]  cmd_word;
  logic               cmd_any;
  logic               cmd_illegal;
  logic               unused_addr_bits;

  // Byte offset bits are dropped and upper bits truncated, so addressing wraps modulo depth.
  assign cmd_word         = bus.address[OFFSET_W +: MEM_AW];
  assign unused_addr_bits = ^bus.address;
  assign cmd_any          = bus.read | bus.write;
  assign cmd_illegal      = (bus.read & bus.write) | (bus.burstcount == '0);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    ready_d     = 1'b1;
    proto_err_d = proto_err_q;
    waitrequest = 1'b1;
    mem_addr    = addr_q;
    mem_we      = 1'b0;
    mem_re      = 1'b0;
    mem_be      = '0;
    mem_wdata   = '0;

    case (state_q)
      IDLE: begin
        waitrequest = !ready_q;
        if (ready_q && cmd_any) begin
          if (cmd_illegal) begin
            proto_err_d = 1'b1;
          end else if (bus.read) begin
            addr_d      = cmd_word;
            remaining_d = bus.burstcount;
            state_d     = RD_BURST;
          end else begin
            // First write beat goes straight to memory in the accept cycle.
            mem_we    = 1'b1;
            mem_addr  = cmd_word;
            mem_wdata = bus.writedata;
            mem_be    = bus.byteenable;
            if (bus.burstcount != BURST_W'(1)) begin
              addr_d      = cmd_word + MEM_AW'(1);
              remaining_d = bus.burstcount - BURST_W'(1);
              state_d     = WR_BURST;
            end
          end
        end
      end

      RD_BURST: begin
        mem_re      = 1'b1;
        addr_d      = addr_q + MEM_AW'(1);
        remaining_d = remaining_q - BURST_W'(1);
        if (remaining_q == BURST_W'(1)) begin
          state_d = IDLE;
        end
      end

      WR_BURST: begin
        waitrequest = 1'b0;
        if (bus.read) begin
          proto_err_d = 1'b1;
        end
        if (bus.write) begin
          mem_we      = 1'b1;
          mem_wdata   = bus.writedata;
          mem_be      = bus.byteenable;
          addr_d      = addr_q + MEM_AW'(1);
          remaining_d = remaining_q - BURST_W'(1);
          if (remaining_q == BURST_W'(1)) begin
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    rvalid_d = mem_re;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      ready_q     <= 1'b0;
      proto_err_q <= 1'b0;
      rvalid_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      ready_q     <= ready_d;
      proto_err_q <= proto_err_d;
      rvalid_q    <= rvalid_d;
    end
  end

  // The BRAM output register supplies the read pipeline stage; gate it so idle readdata is 0.
  assign bus.readdata      = rvalid_q ? mem_q : '0;
  assign bus.readdatavalid = rvalid_q;
  assign bus.waitrequest   = waitrequest;
  assign proto_err         = proto_err_q;
endmodule
`default_nettype wire

// File: tb/tb_avmm_burst_responder.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_avmm_burst_responder : randomized checks against a memory reference model|
// | Revision 1.0                                                                |
// +----------------------------------------------------------------------------+
module tb_avmm_burst_responder;
  localparam int DW    = 128;
  localparam int AW    = 32;
  localparam int MAW   = 12;
  localparam int BW    = 5;
  localparam int BEW   = DW / 8;
  localparam int OFF   = $clog2(BEW);
  localparam int DEPTH = 1 << MAW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  avmm_burst_responder_if #(.DATA_W(DW), .ADDR_W(AW), .BURST_W(BW)) bus();

  logic [MAW-1:0] mem_addr;
  logic           mem_we, mem_re, proto_err;
  logic [BEW-1:0] mem_be;
  logic [DW-1:0]  mem_wdata;
  logic [DW-1:0]  mem_q;

  avmm_burst_responder #(.DATA_W(DW), .ADDR_W(AW), .MEM_AW(MAW), .BURST_W(BW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_be    (mem_be),
    .mem_wdata (mem_wdata),
    .mem_re    (mem_re),
    .mem_q     (mem_q),
    .proto_err (proto_err)
  );

  // Environment BRAM with a preload port.
  logic [DW-1:0]  bram [DEPTH];
  logic           pl_en = 1'b0;
  logic [MAW-1:0] pl_addr = '0;
  logic [DW-1:0]  pl_data = '0;
  always @(posedge clk) begin
    if (pl_en) bram[pl_addr] <= pl_data;
    else if (mem_we)
      for (int b = 0; b < BEW; b++) if (mem_be[b]) bram[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
    if (mem_re) mem_q <= bram[mem_addr];
  end

  // Reference model state and observation logs.
  logic [DW-1:0]  ref_mem [DEPTH];
  logic [DW-1:0]  wd_tbl [32];
  logic [BEW-1:0] be_tbl [32];
  int cyc = 0;
  int rdv_cyc[$];
  logic [DW-1:0] rdv_dat[$];
  int we_addr[$];
  logic [DW-1:0] we_dat[$];
  logic [BEW-1:0] we_be[$];
  int re_addr[$];
  int both_cnt = 0;
  int n_checks = 0;
  int n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.readdatavalid) begin rdv_cyc.push_back(cyc); rdv_dat.push_back(bus.readdata); end
    if (mem_we) begin we_addr.push_back(int'(mem_addr)); we_dat.push_back(mem_wdata); we_be.push_back(mem_be); end
    if (mem_re) re_addr.push_back(int'(mem_addr));
    if (mem_we && mem_re) both_cnt++;
  end

  function automatic int wordof(input logic [AW-1:0] a);
    return int'(a[OFF +: MAW]);
  endfunction

  task automatic issue_read(input logic [AW-1:0] a, input int n, output int acc);
    bit got;
    got = 1'b0;
    acc = -1;
    @(posedge clk); #1;
    bus.address = a; bus.burstcount = BW'(n); bus.read = 1'b1; bus.write = 1'b0;
    for (int t = 0; t < 40 && !got; t++) begin
      @(negedge clk);
      if (!bus.waitrequest) begin got = 1'b1; acc = cyc; end
    end
    @(posedge clk); #1;
    bus.read = 1'b0;
  endtask

  // Drives a write burst from wd_tbl/be_tbl and applies each beat to the reference memory.
  task automatic issue_write(input logic [AW-1:0] a, input int n, input int stall_at, input int stall_n);
    bit got;
    int wi;
    @(posedge clk); #1;
    for (int i = 0; i < n; i++) begin
      bus.address = a; bus.burstcount = BW'(n); bus.read = 1'b0; bus.write = 1'b1;
      bus.writedata = wd_tbl[i]; bus.byteenable = be_tbl[i];
      got = 1'b0;
      for (int t = 0; t < 40 && !got; t++) begin
        @(negedge clk);
        if (!bus.waitrequest) got = 1'b1;
      end
      @(posedge clk); #1;
      wi = (wordof(a) + i) % DEPTH;
      for (int b = 0; b < BEW; b++) if (be_tbl[i][b]) ref_mem[wi][b*8 +: 8] = wd_tbl[i][b*8 +: 8];
      if (i == stall_at) begin
        bus.write = 1'b0;
        repeat (stall_n) @(posedge clk);
        #1;
      end
    end
    bus.write = 1'b0;
  endtask

  task automatic preload_all();
    logic [DW-1:0] v;
    @(posedge clk); #1;
    pl_en = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      v = (i <= 10) ? {BEW{8'(i)}} : {$urandom(), $urandom(), $urandom(), $urandom()};
      pl_addr = MAW'(i); pl_data = v; ref_mem[i] = v;
      @(posedge clk); #1;
    end
    pl_en = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++; if (bus.waitrequest !== 1'b1) $display("FAIL reset_waitrequest: got %b want 1", bus.waitrequest); else n_pass++;
    n_checks++; if (bus.readdatavalid !== 1'b0) $display("FAIL reset_rdv: got %b want 0", bus.readdatavalid); else n_pass++;
    n_checks++; if (bus.readdata !== '0) $display("FAIL reset_readdata: got %h want 0", bus.readdata); else n_pass++;
    n_checks++; if ({mem_we, mem_re} !== 2'b00) $display("FAIL reset_strobes: got we=%b re=%b want 0 0", mem_we, mem_re); else n_pass++;
    n_checks++; if (proto_err !== 1'b0) $display("FAIL reset_proto_err: got %b want 0", proto_err); else n_pass++;
    rst_n = 1'b1;
    #1;
    n_checks++; if (bus.waitrequest !== 1'b1) $display("FAIL release_waitrequest: got %b want 1", bus.waitrequest); else n_pass++;
    @(negedge clk);
    n_checks++; if (bus.waitrequest !== 1'b0) $display("FAIL ready_after_edge: got %b want 0", bus.waitrequest); else n_pass++;
  endtask

  task automatic test_read_burst();
    int acc, m, mr, hi;
    m = rdv_cyc.size(); mr = re_addr.size(); hi = 0;
    issue_read(32'h0, 11, acc);
    for (int i = 0; i < 11; i++) begin @(negedge clk); if (bus.waitrequest) hi++; end
    n_checks++; if (hi !== 11) $display("FAIL rd_wait_cycles: got %0d want 11", hi); else n_pass++;
    @(negedge clk);
    n_checks++; if (bus.waitrequest !== 1'b0) $display("FAIL rd_idle_after: got %b want 0", bus.waitrequest); else n_pass++;
    @(negedge clk);
    n_checks++; if (rdv_cyc.size() - m !== 11 || re_addr.size() - mr !== 11)
      $display("FAIL rd_beats: got rdv=%0d re=%0d want 11 11", rdv_cyc.size() - m, re_addr.size() - mr); else n_pass++;
    for (int i = 0; i < 11 && m + i < rdv_cyc.size(); i++) begin
      n_checks++;
      if (rdv_cyc[m+i] !== acc + 2 + i || rdv_dat[m+i] !== {BEW{8'(i)}} || re_addr[mr+i] !== i)
        $display("FAIL rd_beat%0d: got cyc=%0d data=%h addr=%0d want cyc=%0d data=%h addr=%0d",
                 i, rdv_cyc[m+i], rdv_dat[m+i], re_addr[mr+i], acc + 2 + i, {BEW{8'(i)}}, i);
      else n_pass++;
    end
  endtask

  task automatic test_write_burst();
    int acc, mw, m;
    logic [DW-1:0] exp;
    for (int i = 0; i < 11; i++) begin wd_tbl[i] = DW'(8'hA0 + i); be_tbl[i] = '1; end
    mw = we_addr.size();
    issue_write(32'hB0, 11, -1, 0);
    n_checks++; if (we_addr.size() - mw !== 11) $display("FAIL wr_pulses: got %0d want 11", we_addr.size() - mw); else n_pass++;
    for (int i = 0; i < 11 && mw + i < we_addr.size(); i++) begin
      exp = DW'(8'hA0 + i);
      n_checks++;
      if (we_addr[mw+i] !== 11 + i || we_dat[mw+i] !== exp)
        $display("FAIL wr_beat%0d: got addr=%0d data=%h want addr=%0d data=%h", i, we_addr[mw+i], we_dat[mw+i], 11 + i, exp);
      else n_pass++;
    end
    m = rdv_cyc.size();
    issue_read(32'hB0, 11, acc);
    repeat (13) @(negedge clk);
    n_checks++; if (rdv_cyc.size() - m !== 11) $display("FAIL wr_readback_count: got %0d want 11", rdv_cyc.size() - m); else n_pass++;
    for (int i = 0; i < 11 && m + i < rdv_dat.size(); i++) begin
      exp = DW'(8'hA0 + i);
      n_checks++; if (rdv_dat[m+i] !== exp) $display("FAIL wr_readback%0d: got %h want %h", i, rdv_dat[m+i], exp); else n_pass++;
    end
  endtask

  task automatic test_write_stall();
    int acc, mw, m;
    for (int i = 0; i < 4; i++) begin wd_tbl[i] = {$urandom(), $urandom(), $urandom(), $urandom()}; be_tbl[i] = '1; end
    mw = we_addr.size();
    issue_write(32'h640, 4, 0, 2);
    n_checks++; if (we_addr.size() - mw !== 4) $display("FAIL stall_pulses: got %0d want 4", we_addr.size() - mw); else n_pass++;
    for (int i = 0; i < 4 && mw + i < we_addr.size(); i++) begin
      n_checks++;
      if (we_addr[mw+i] !== 100 + i || we_dat[mw+i] !== wd_tbl[i])
        $display("FAIL stall_beat%0d: got addr=%0d data=%h want addr=%0d data=%h", i, we_addr[mw+i], we_dat[mw+i], 100 + i, wd_tbl[i]);
      else n_pass++;
    end
    m = rdv_cyc.size();
    issue_read(32'h640, 4, acc);
    repeat (6) @(negedge clk);
    n_checks++; if (proto_err !== 1'b0) $display("FAIL stall_idle_after: proto_err got %b want 0", proto_err); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (m + i >= rdv_dat.size() || rdv_dat[m+i] !== ref_mem[100+i])
        $display("FAIL stall_readback%0d: got count=%0d want data %h", i, rdv_dat.size() - m, ref_mem[100+i]);
      else n_pass++;
    end
  endtask

  task automatic test_wrap();
    int acc, m, mr, w;
    m = rdv_cyc.size(); mr = re_addr.size();
    issue_read(32'hFFF0, 3, acc);
    repeat (5) @(negedge clk);
    n_checks++; if (rdv_cyc.size() - m !== 3) $display("FAIL wrap_count: got %0d want 3", rdv_cyc.size() - m); else n_pass++;
    for (int i = 0; i < 3 && m + i < rdv_cyc.size() && mr + i < re_addr.size(); i++) begin
      w = (4095 + i) % DEPTH;
      n_checks++;
      if (re_addr[mr+i] !== w || rdv_dat[m+i] !== ref_mem[w] || rdv_cyc[m+i] !== acc + 2 + i)
        $display("FAIL wrap_beat%0d: got addr=%0d data=%h want addr=%0d data=%h", i, re_addr[mr+i], rdv_dat[m+i], w, ref_mem[w]);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    int acc, n, m, mw, sa, w;
    logic [MAW-1:0] wv;
    logic [31:0] r;
    logic [AW-1:0] a;
    for (int it = 0; it < 14; it++) begin
      n = $urandom_range(1, 16); wv = MAW'($urandom_range(0, DEPTH - 1)); r = $urandom();
      a = {r[31:16], wv, 4'h0}; w = int'(wv);
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i < n; i++) begin
          wd_tbl[i] = {$urandom(), $urandom(), $urandom(), $urandom()}; be_tbl[i] = BEW'($urandom());
        end
        sa = $urandom_range(0, n - 1);
        mw = we_addr.size();
        issue_write(a, n, sa, $urandom_range(0, 2));
        n_checks++; if (we_addr.size() - mw !== n) $display("FAIL rnd%0d_wr_count: got %0d want %0d", it, we_addr.size() - mw, n); else n_pass++;
        for (int i = 0; i < n && mw + i < we_addr.size(); i++) begin
          n_checks++;
          if (we_addr[mw+i] !== (w + i) % DEPTH || we_dat[mw+i] !== wd_tbl[i] || we_be[mw+i] !== be_tbl[i])
            $display("FAIL rnd%0d_wr_beat%0d: got addr=%0d be=%h want addr=%0d be=%h", it, i, we_addr[mw+i], we_be[mw+i], (w + i) % DEPTH, be_tbl[i]);
          else n_pass++;
        end
      end else begin
        m = rdv_cyc.size();
        issue_read(a, n, acc);
        repeat (n + 3) @(negedge clk);
        n_checks++; if (rdv_cyc.size() - m !== n) $display("FAIL rnd%0d_rd_count: got %0d want %0d", it, rdv_cyc.size() - m, n); else n_pass++;
        for (int i = 0; i < n && m + i < rdv_cyc.size(); i++) begin
          n_checks++;
          if (rdv_cyc[m+i] !== acc + 2 + i || rdv_dat[m+i] !== ref_mem[(w + i) % DEPTH])
            $display("FAIL rnd%0d_rd_beat%0d: got cyc=%0d data=%h want cyc=%0d data=%h", it, i, rdv_cyc[m+i], rdv_dat[m+i], acc + 2 + i, ref_mem[(w + i) % DEPTH]);
          else n_pass++;
        end
      end
    end
    n_checks++; if (both_cnt !== 0) $display("FAIL strobe_exclusive: got %0d overlaps want 0", both_cnt); else n_pass++;
    n_checks++; if (proto_err !== 1'b0) $display("FAIL rnd_proto_err: got %b want 0", proto_err); else n_pass++;
  endtask

  task automatic test_illegal();
    int acc, m, mw, mr;
    mw = we_addr.size(); mr = re_addr.size();
    @(posedge clk); #1;
    bus.address = 32'h50; bus.burstcount = '0; bus.read = 1'b1; bus.write = 1'b0;
    @(posedge clk); #1;
    bus.read = 1'b0;
    @(negedge clk);
    n_checks++; if (proto_err !== 1'b1) $display("FAIL illegal_bc0: proto_err got %b want 1", proto_err); else n_pass++;
    @(posedge clk); #1;
    bus.burstcount = BW'(2); bus.read = 1'b1; bus.write = 1'b1; bus.writedata = '1; bus.byteenable = '1;
    @(posedge clk); #1;
    bus.read = 1'b0; bus.write = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (we_addr.size() !== mw || re_addr.size() !== mr)
      $display("FAIL illegal_no_access: got we=%0d re=%0d want 0 0", we_addr.size() - mw, re_addr.size() - mr); else n_pass++;
    n_checks++; if (proto_err !== 1'b1) $display("FAIL illegal_sticky: proto_err got %b want 1", proto_err); else n_pass++;
    m = rdv_cyc.size();
    issue_read(32'h50, 2, acc);
    repeat (4) @(negedge clk);
    n_checks++; if (rdv_cyc.size() - m !== 2) $display("FAIL illegal_then_read: got %0d beats want 2", rdv_cyc.size() - m);
    else if (rdv_dat[m] !== ref_mem[5] || rdv_dat[m+1] !== ref_mem[6]) $display("FAIL illegal_then_read: got %h want %h", rdv_dat[m], ref_mem[5]);
    else n_pass++;
  endtask

  task automatic test_reset_mid_burst();
    int acc, m, m2;
    m = rdv_cyc.size();
    issue_read(32'h0, 11, acc);
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (bus.readdatavalid !== 1'b0 || bus.waitrequest !== 1'b1 || mem_re !== 1'b0)
      $display("FAIL midrst_outputs: got rdv=%b wait=%b re=%b want 0 1 0", bus.readdatavalid, bus.waitrequest, mem_re); else n_pass++;
    repeat (2) @(negedge clk);
    n_checks++; if (rdv_cyc.size() - m !== 3) $display("FAIL midrst_beats: got %0d want 3", rdv_cyc.size() - m); else n_pass++;
    rst_n = 1'b1;
    #1;
    n_checks++; if (bus.waitrequest !== 1'b1 || proto_err !== 1'b0)
      $display("FAIL midrst_release: got wait=%b perr=%b want 1 0", bus.waitrequest, proto_err); else n_pass++;
    @(negedge clk);
    n_checks++; if (bus.waitrequest !== 1'b0) $display("FAIL midrst_ready: got %b want 0", bus.waitrequest); else n_pass++;
    m2 = rdv_cyc.size();
    issue_read(32'h40, 3, acc);
    repeat (5) @(negedge clk);
    n_checks++; if (rdv_cyc.size() - m2 !== 3) $display("FAIL midrst_new_count: got %0d want 3", rdv_cyc.size() - m2); else n_pass++;
    for (int i = 0; i < 3 && m2 + i < rdv_cyc.size(); i++) begin
      n_checks++;
      if (rdv_cyc[m2+i] !== acc + 2 + i || rdv_dat[m2+i] !== ref_mem[4+i])
        $display("FAIL midrst_new_beat%0d: got cyc=%0d data=%h want cyc=%0d data=%h", i, rdv_cyc[m2+i], rdv_dat[m2+i], acc + 2 + i, ref_mem[4+i]);
      else n_pass++;
    end
  endtask

  initial begin
    bus.address = '0; bus.burstcount = '0; bus.read = 1'b0; bus.write = 1'b0;
    bus.writedata = '0; bus.byteenable = '0;
    preload_all();
    test_reset();
    test_read_burst();
    test_write_burst();
    test_write_stall();
    test_wrap();
    test_random();
    test_illegal();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no completion want summary");
    $fatal(1);
  end
endmodule
`default_nettype wire

// File: doc/avmm_burst_responder.md
Name: avmm_burst_responder

Overview:
- Avalon-MM burst slave (responder) that fronts a synchronous-read BRAM. It is the memory-side counterpart to the register-file load/store initiator.
- Serves as an on-chip SDRAM stand-in for simulation and FPGA bring-up.
- Accepts one read or write burst at a time, translates byte addresses to word addresses, and drives the BRAM port.
- Returns read data with readdatavalid.

Parameters:
- DATA_W, 128, data beat width in bits; a multiple of 8.
- ADDR_W, 32, Avalon byte-address width.
- MEM_AW, 12, BRAM word-address width (depth = 2**MEM_AW words).
- BURST_W, 5, burstcount width; legal burstcount 1..2**(BURST_W-1).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- address  in  ADDR_W  byte address of first beat; must be DATA_W/8 aligned
- burstcount  in  BURST_W  beats in burst
- read  in  1  read command
- write  in  1  write command / write data beat strobe
- writedata  in  DATA_W  write beat data
- byteenable  in  DATA_W/8  per-byte write enable
- waitrequest  out  1  slave not ready; command/beat not accepted
- readdata  out  DATA_W  read beat data
- readdatavalid  out  1  readdata valid this cycle
- mem_addr  out  MEM_AW  BRAM word address
- mem_we  out  1  BRAM write enable
- mem_be  out  DATA_W/8  BRAM byte enables
- mem_wdata  out  DATA_W  BRAM write data
- mem_re  out  1  BRAM read enable; mem_q valid the following cycle
- mem_q  in  DATA_W  BRAM read data
- proto_err  out  1  sticky protocol-violation flag

Behaviour:
- Word address = address[log2(DATA_W/8) +: MEM_AW]. Low bits are ignored. Upper bits are truncated, so addresses wrap modulo depth; burst address increments also wrap.
- Reset values: waitrequest=1, readdatavalid=0, readdata=0, mem_we=0, mem_re=0, proto_err=0, state=IDLE. Registered ready flag is 0 in reset and goes to 1 on the first clk edge after release.
- waitrequest:
  - IDLE: !ready
  - RD_BURST: 1
  - WR_BURST: 0
- IDLE, accepting a read (read=1, write=0, burstcount!=0, ready):
  - latch word address and remaining=burstcount;
  - go to RD_BURST.
- IDLE, accepting a write (write=1, read=0, burstcount!=0, ready):
  - first beat is written the same cycle: mem_we=1, mem_addr=word address, mem_wdata=writedata, mem_be=byteenable;
  - if burstcount==1, stay IDLE;
  - else latch addr+1, remaining=burstcount-1, go to WR_BURST.
- IDLE, illegal command (read&write both 1, or burstcount==0 with read|write): set proto_err, perform no memory access, stay IDLE.
- RD_BURST:
  - each cycle: mem_re=1, mem_addr=addr, addr+=1, remaining-=1;
  - when the beat with remaining==1 issues, go to IDLE.
- Read return: readdatavalid and readdata (=mem_q) are registered one cycle after each mem_re.
  - First readdatavalid arrives 2 cycles after the read is accepted; N beats are contiguous.
  - The last readdatavalid can coincide with IDLE accepting a new command.
- WR_BURST:
  - write=1: write the beat at addr, addr+=1, remaining-=1; when remaining reaches 0, go to IDLE.
  - write=0: stall; no memory write, state held.
  - read=1: set proto_err, ignore the read.
- Memory strobe exclusivity: mem_we and mem_re are never both 1.
- Non-write cycles: mem_be and mem_wdata are don't-care, but driven 0.
- proto_err is cleared only by reset.
- Reset mid-burst: immediate return to IDLE with all outputs at reset values. Pending readdatavalid is dropped.
- Throughput: 1 beat/cycle for both directions. Turnaround is 1 IDLE cycle between bursts.

Test Plan:
- Preload words 0..10 with i*0x0101...; read, address=0x0, burstcount=11 -> waitrequest=0 at accept; 11 contiguous readdatavalid starting accept+2 with data i; waitrequest=1 for 11 cycles.
- Write burst, address=0xB0, burstcount=11, data 0xA0+i, byteenable all-ones -> mem_we at word addresses 11..21; readback burst returns 0xA0+i.
- Write burst of 4 with write deasserted for 2 cycles after beat 1 -> exactly 4 mem_we pulses, addresses contiguous, no duplicate beats; IDLE after the 4th.
- Address 0xFFF0 (word 4095), burstcount=3, read -> mem_addr 4095, 0, 1 (wrap); 3 readdatavalid.
- Illegal commands: burstcount=0 with read=1, and read&write simultaneously -> proto_err=1 sticky, no mem_re/mem_we; a subsequent legal read still served.
- Assert rst_n low in the 5th beat of an 11-beat read -> readdatavalid=0 immediately, waitrequest=1; after release, one cycle of waitrequest=1, then a new burst is accepted correctly.
